fir_param: RTL and testbench
============================

FIR_PARAM -- requirements
Module: fir_param

Interface
REQ-001 SHALL have parameter IN_W, default 4, signed input sample width.
REQ-002 SHALL have parameter COEF_W, default 8, signed coefficient width.
REQ-003 SHALL have parameter TAPS, default 5, number of taps (2..32).
REQ-004 SHALL have parameter OUT_W, default 16, signed output width.
REQ-005 SHALL have parameter SAT, default 1: 1 = saturate Out, 0 = two's-complement wrap.
REQ-006 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port In  input  IN_W  signed sample.
REQ-009 SHALL have port in_valid  input  1  In accepted at this edge.
REQ-010 SHALL have port clear  input  1  synchronous flush of the delay line.
REQ-011 SHALL have port coef_we  input  1  coefficient write strobe.
REQ-012 SHALL have port coef_addr  input  5  tap index to write.
REQ-013 SHALL have port coef_data  input  COEF_W  signed coefficient value.
REQ-014 SHALL have port Out  output  OUT_W  signed filter result, registered.
REQ-015 SHALL have port out_valid  output  1  Out updated this cycle, registered.
REQ-016 SHALL have port ovf  output  1  sticky overflow flag, registered.

Function
REQ-017 SHALL hold delay line x[0..TAPS-1] (IN_W each) and coefficient registers c[0..TAPS-1] (COEF_W each).
REQ-018 On an edge with in_valid=1 and clear=0: x[0]<=In, x[k]<=x[k-1] for k>=1.
REQ-019 On an edge with in_valid=0 and clear=0: delay line holds.
REQ-020 Sum S = sum over k of c[k]*x[k], computed at full precision ACC_W = IN_W+COEF_W+ceil(log2(TAPS)) with sign extension.
REQ-021 Latency: sample accepted at edge N -> Out reflecting S including it and out_valid=1 after edge N+1; out_valid is a one-cycle pulse per accepted sample.
REQ-022 Back-to-back in_valid SHALL give one result per cycle (throughput 1).
REQ-023 When no result is produced, out_valid=0 and Out holds its last value.
REQ-024 SAT=1: S > 2^(OUT_W-1)-1 -> Out = max; S < -2^(OUT_W-1) -> Out = min; else Out = S.
REQ-025 SAT=0: Out = low OUT_W bits of S.
REQ-026 ovf SHALL set on any produced result whose S is outside the OUT_W signed range; stays set until clear or reset.
REQ-027 coef_we=1 with coef_addr<TAPS writes c[coef_addr]<=coef_data at that edge; coef_addr>=TAPS is ignored, no state change.
REQ-028 Coefficient write and in_valid at the same edge: both take effect; the result registered at the next edge uses the new coefficient.
REQ-029 clear=1: all x[k]<=0, ovf<=0, pending result dropped (out_valid=0 next cycle), Out holds; clear has priority over in_valid; coefficients unaffected.
REQ-030 Coefficient write during clear SHALL still be performed.

Reset
REQ-031 rst_n=0 SHALL immediately, independent of clk, force x[k]=0, Out=0, out_valid=0, ovf=0.
REQ-032 Reset SHALL load c = {1,4,16,4,1} for k=0..4 and 0 for k>=5.
REQ-033 Reset asserted mid-stream SHALL discard pending results; first out_valid after release requires a new in_valid.

Verification
REQ-034 Impulse (defaults): In=1 one cycle then 0 with in_valid held -> Out = 1,4,16,4,1,0 on consecutive out_valid pulses.
REQ-035 Step: In=4'hF held, in_valid=1 -> Out = -1,-5,-21,-25,-26, then -26 steady; ovf=0.
REQ-036 Reload: write c[2]=-3 then impulse -> Out = 1,4,-3,4,1.
REQ-037 Saturation: OUT_W=8, SAT=1, In=-8 held -> Out = -8,-40,-128,-128,...; ovf=1 from the third result (S=-168); SAT=0 same stimulus third result = 88.
REQ-038 Clear/gaps: impulse, clear asserted two cycles later -> no out_valid next cycle, then zeros; in_valid gaps -> out_valid gaps, Out held.
REQ-039 Reset mid-stream between edges -> Out=0, out_valid=0, ovf=0 immediately; coefficients back to defaults.

Source files
------------

// File: rtl/fir_param.sv
// fir_param: parameterised direct-form FIR filter with a writable coefficient
// bank, one-cycle result register, optional output saturation and a sticky
// overflow flag.
module fir_param #(
    parameter int unsigned IN_W   = 4,
    parameter int unsigned COEF_W = 8,
    parameter int unsigned TAPS   = 5,
    parameter int unsigned OUT_W  = 16,
    parameter int unsigned SAT    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IN_W-1:0]     In,
    input  logic                in_valid,
    input  logic                clear,
    input  logic                coef_we,
    input  logic [4:0]          coef_addr,
    input  logic [COEF_W-1:0]   coef_data,
    output logic [OUT_W-1:0]    Out,
    output logic                out_valid,
    output logic                ovf
);

    localparam int unsigned PROD_W = IN_W + COEF_W;
    localparam int unsigned ACC_W  = PROD_W + $clog2(TAPS);
    // One guard bit above the wider of accumulator and output so range
    // checks never lose the sign.
    localparam int unsigned EXT_W  = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

    localparam logic signed [EXT_W-1:0] MAX_V =
        {{(EXT_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [EXT_W-1:0] MIN_V =
        {{(EXT_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic signed [IN_W-1:0]   x_q    [TAPS];
    logic signed [COEF_W-1:0] c_q    [TAPS];
    logic signed [PROD_W-1:0] prod_c [TAPS];
    logic signed [ACC_W-1:0]  acc_c;
    logic signed [EXT_W-1:0]  s_ext_c;
    logic                     hi_c;
    logic                     lo_c;
    logic [OUT_W-1:0]         res_c;
    logic                     pend_q;

    // Power-on coefficient set: a small symmetric low-pass kernel.
    function automatic logic signed [COEF_W-1:0] coef_default(input int unsigned k);
        logic signed [COEF_W-1:0] v;
        case (k)
            0:       v = COEF_W'(1);
            1:       v = COEF_W'(4);
            2:       v = COEF_W'(16);
            3:       v = COEF_W'(4);
            4:       v = COEF_W'(1);
            default: v = '0;
        endcase
        return v;
    endfunction

    // Delay line: flush on clear, shift on an accepted sample, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < TAPS; k++) x_q[k] <= '0;
        end else if (clear) begin
            for (int unsigned k = 0; k < TAPS; k++) x_q[k] <= '0;
        end else if (in_valid) begin
            x_q[0] <= In;
            for (int unsigned k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
        end
    end

    // Coefficient bank: out-of-range addresses match no tap and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < TAPS; k++) c_q[k] <= coef_default(k);
        end else begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                if (coef_we && (coef_addr == 5'(k))) c_q[k] <= coef_data;
            end
        end
    end

    // Marks that the delay line took a sample, so a result is due next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= 1'b0;
        else        pend_q <= in_valid & ~clear;
    end

    // Full-precision sum of products over the current delay line.
    always_comb begin
        acc_c = '0;
        for (int unsigned k = 0; k < TAPS; k++) begin
            prod_c[k] = PROD_W'(x_q[k]) * PROD_W'(c_q[k]);
            acc_c     = acc_c + ACC_W'(prod_c[k]);
        end
    end

    // Range detection and saturate-or-wrap selection of the output value.
    always_comb begin
        s_ext_c = EXT_W'(acc_c);
        hi_c    = (s_ext_c > MAX_V);
        lo_c    = (s_ext_c < MIN_V);
        res_c   = s_ext_c[OUT_W-1:0];
        if (SAT != 0) begin
            if (hi_c)      res_c = MAX_V[OUT_W-1:0];
            else if (lo_c) res_c = MIN_V[OUT_W-1:0];
        end
    end

    // Result register: clear drops the pending result and the overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Out       <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else if (clear) begin
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else if (pend_q) begin
            Out       <= res_c;
            out_valid <= 1'b1;
            ovf       <= ovf | hi_c | lo_c;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_param.sv
// Directed bench for fir_param: default instance plus two 8-bit-output
// instances (saturating and wrapping) driven from the same stimulus.
module tb_fir_param;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        in_s;
    logic              in_valid;
    logic              clear;
    logic              coef_we;
    logic [4:0]        coef_addr;
    logic [7:0]        coef_data;

    logic signed [15:0] out_d;
    logic               vld_d, ovf_d;
    logic signed [7:0]  out_s;
    logic               vld_s, ovf_s;
    logic signed [7:0]  out_w;
    logic               vld_w, ovf_w;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fir_param u_dut (
        .clk(clk), .rst_n(rst_n), .In(in_s), .in_valid(in_valid), .clear(clear),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .Out(out_d), .out_valid(vld_d), .ovf(ovf_d)
    );

    fir_param #(.OUT_W(8), .SAT(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .In(in_s), .in_valid(in_valid), .clear(clear),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .Out(out_s), .out_valid(vld_s), .ovf(ovf_s)
    );

    fir_param #(.OUT_W(8), .SAT(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .In(in_s), .in_valid(in_valid), .clear(clear),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .Out(out_w), .out_valid(vld_w), .ovf(ovf_w)
    );

    typedef struct {
        logic [3:0] in;
        logic       iv;
        logic       clr;
        logic       we;
        logic [4:0] addr;
        logic [7:0] data;
        logic       ev;
        int         eo;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [3:0] i, input logic v, input logic c,
                                input logic w, input logic [4:0] a, input logic [7:0] d,
                                input logic ev, input int eo);
        vec_t t;
        t.in = i; t.iv = v; t.clr = c; t.we = w; t.addr = a; t.data = d;
        t.ev = ev; t.eo = eo;
        vecs.push_back(t);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Drive one set of inputs at the falling edge, then sample after the rising edge.
    task automatic step(input logic [3:0] i, input logic v, input logic c,
                        input logic w, input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        in_s = i; in_valid = v; clear = c; coef_we = w; coef_addr = a; coef_data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_s = '0; in_valid = 1'b0; clear = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        #1;
        check("reset_out",   int'(out_d), 0);
        check("reset_valid", int'(vld_d), 0);
        check("reset_ovf",   int'(ovf_d), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Impulse with default coefficients
        add(4'h1, 1, 0, 0, 0, 8'h00, 0,   0);
        add(4'h0, 1, 0, 0, 0, 8'h00, 1,   1);
        add(4'h0, 1, 0, 0, 0, 8'h00, 1,   4);
        add(4'h0, 1, 0, 0, 0, 8'h00, 1,  16);
        add(4'h0, 1, 0, 0, 0, 8'h00, 1,   4);
        add(4'h0, 1, 0, 0, 0, 8'h00, 1,   1);
        add(4'h0, 0, 0, 0, 0, 8'h00, 1,   0);
        add(4'h0, 0, 0, 0, 0, 8'h00, 0,   0);
        // Step of -1
        add(4'hF, 1, 0, 0, 0, 8'h00, 0,   0);
        add(4'hF, 1, 0, 0, 0, 8'h00, 1,  -1);
        add(4'hF, 1, 0, 0, 0, 8'h00, 1,  -5);
        add(4'hF, 1, 0, 0, 0, 8'h00, 1, -21);
        add(4'hF, 1, 0, 0, 0, 8'h00, 1, -25);
        add(4'hF, 1, 0, 0, 0, 8'h00, 1, -26);
        add(4'hF, 1, 0, 0, 0, 8'h00, 1, -26);
        add(4'hF, 0, 0, 0, 0, 8'h00, 1, -26);
        // Gaps: no pulse, Out held
        add(4'h0, 0, 0, 0, 0, 8'h00, 0, -26);
        add(4'hF, 1, 0, 0, 0, 8'h00, 0, -26);
        add(4'h0, 0, 0, 0, 0, 8'h00, 1, -26);
        add(4'h0, 0, 0, 0, 0, 8'h00, 0, -26);
        // Clear, reload c[2]=-3, ignored out-of-range write, impulse
        add(4'h0, 0, 1, 0, 0, 8'h00, 0, -26);
        add(4'h0, 0, 0, 1, 2, 8'hFD, 0, -26);
        add(4'h0, 0, 0, 1, 7, 8'h55, 0, -26);
        add(4'h1, 1, 0, 0, 0, 8'h00, 0, -26);
        add(4'h0, 1, 0, 0, 0, 8'h00, 1,   1);
        add(4'h0, 1, 0, 0, 0, 8'h00, 1,   4);
        add(4'h0, 1, 0, 0, 0, 8'h00, 1,  -3);
        add(4'h0, 1, 0, 0, 0, 8'h00, 1,   4);
        add(4'h0, 1, 0, 0, 0, 8'h00, 1,   1);
        add(4'h0, 1, 0, 0, 0, 8'h00, 1,   0);
        // Impulse then clear two cycles later drops the pending result
        add(4'h1, 1, 0, 0, 0, 8'h00, 1,   0);
        add(4'h0, 1, 0, 0, 0, 8'h00, 1,   1);
        add(4'h0, 1, 1, 0, 0, 8'h00, 0,   1);
        add(4'h0, 1, 0, 0, 0, 8'h00, 0,   1);
        add(4'h0, 1, 0, 0, 0, 8'h00, 1,   0);
        // Coefficient write during clear, then write together with a sample
        add(4'h0, 0, 1, 1, 2, 8'h10, 0,   0);
        add(4'h1, 1, 0, 1, 0, 8'h02, 0,   0);
        add(4'h0, 1, 0, 0, 0, 8'h00, 1,   2);
        add(4'h0, 1, 0, 0, 0, 8'h00, 1,   4);
        add(4'h0, 1, 0, 0, 0, 8'h00, 1,  16);

        foreach (vecs[i]) begin
            step(vecs[i].in, vecs[i].iv, vecs[i].clr, vecs[i].we, vecs[i].addr, vecs[i].data);
            check($sformatf("vec%0d_valid", i), int'(vld_d), int'(vecs[i].ev));
            if (vecs[i].ev) check($sformatf("vec%0d_out", i), int'(out_d), vecs[i].eo);
            check($sformatf("vec%0d_ovf", i), int'(ovf_d), 0);
        end
        check("hold_out_final", int'(out_d), 16);

        // Stream of -8 with c = {2,4,16,4,1}, delay line [0,0,0,1,0]
        step(4'h8, 1, 0, 0, 0, 8'h00);
        check("mid_r1", int'(out_d), 4);
        step(4'h8, 1, 0, 0, 0, 8'h00);
        check("mid_r2", int'(out_d), -15);
        step(4'h8, 1, 0, 0, 0, 8'h00);
        check("mid_r3", int'(out_d), -48);
        step(4'h8, 1, 0, 0, 0, 8'h00);
        check("mid_r4", int'(out_d), -176);
        check("mid_r4_valid", int'(vld_d), 1);
        check("mid_sat_ovf", int'(ovf_s), 1);

        // Asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out",   int'(out_d), 0);
        check("async_rst_valid", int'(vld_d), 0);
        check("async_rst_ovf_s", int'(ovf_s), 0);
        check("async_rst_out_s", int'(out_s), 0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // No result after release without a fresh sample
        step(4'h8, 0, 0, 0, 0, 8'h00);
        check("post_rst_valid", int'(vld_d), 0);
        step(4'h8, 1, 0, 0, 0, 8'h00);
        check("post_rst_valid2", int'(vld_d), 0);

        // Saturation vs. wrap with default coefficients, In=-8 held
        step(4'h8, 1, 0, 0, 0, 8'h00);
        check("sat_r1", int'(out_s), -8);
        check("wrap_r1", int'(out_w), -8);
        check("dflt_r1", int'(out_d), -8);
        check("sat_r1_valid", int'(vld_s), 1);
        step(4'h8, 1, 0, 0, 0, 8'h00);
        check("sat_r2", int'(out_s), -40);
        check("sat_r2_ovf", int'(ovf_s), 0);
        step(4'h8, 1, 0, 0, 0, 8'h00);
        check("sat_r3", int'(out_s), -128);
        check("wrap_r3", int'(out_w), 88);
        check("dflt_r3", int'(out_d), -168);
        check("sat_r3_ovf", int'(ovf_s), 1);
        check("wrap_r3_ovf", int'(ovf_w), 1);
        check("dflt_r3_ovf", int'(ovf_d), 0);
        step(4'h8, 1, 0, 0, 0, 8'h00);
        check("sat_r4", int'(out_s), -128);
        check("wrap_r4", int'(out_w), 56);
        step(4'h8, 0, 0, 0, 0, 8'h00);
        check("sat_r5", int'(out_s), -128);
        check("wrap_r5", int'(out_w), 48);
        check("dflt_r5", int'(out_d), -208);
        check("sat_r5_ovf_sticky", int'(ovf_s), 1);
        step(4'h0, 0, 1, 0, 0, 8'h00);
        check("clear_ovf_s", int'(ovf_s), 0);
        check("clear_hold_s", int'(out_s), -128);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
